// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per functional unit, round-robin
// selection of one buffered result per cycle onto a registered CDB packet.
module cdb_arbiter #(
   parameter int N_FU  = 4,
   parameter int TAG_W = 5,
   parameter int XLEN  = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [N_FU-1:0]         fu_valid,
   input  logic [N_FU*TAG_W-1:0]   fu_rob_tag,
   input  logic [N_FU*XLEN-1:0]    fu_value,
   output logic [N_FU-1:0]         fu_ready,
   input  logic                    squash,
   output logic                    cdb_valid,
   output logic [TAG_W-1:0]        cdb_rob_tag,
   output logic [XLEN-1:0]         cdb_value,
   output logic [N_FU-1:0]         grant_dbg,
   output logic [31:0]             bcast_count
);

   localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

   logic [N_FU-1:0]             buf_valid_q;
   logic [N_FU-1:0][TAG_W-1:0]  buf_tag_q;
   logic [N_FU-1:0][XLEN-1:0]   buf_value_q;
   logic [PTR_W-1:0]            rr_ptr_q;
   logic [PTR_W-1:0]            rr_ptr_d;
   logic                        cdb_valid_q;
   logic [TAG_W-1:0]            cdb_tag_q;
   logic [XLEN-1:0]             cdb_value_q;
   logic [31:0]                 bcast_count_q;

   logic [N_FU-1:0]             grant;
   logic [N_FU-1:0]             accept;
   logic [PTR_W-1:0]            gidx;
   logic                        found;
   logic [PTR_W:0]              scan_sum;
   logic [PTR_W-1:0]            scan_idx;
   logic [TAG_W-1:0]            g_tag;
   logic [XLEN-1:0]             g_value;

   // Round-robin search starting at rr_ptr; squash suppresses any grant.
   always_comb begin
      grant    = '0;
      gidx     = '0;
      found    = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      if (!squash) begin
         for (int k = 0; k < N_FU; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(N_FU)) begin
               scan_sum = scan_sum - (PTR_W+1)'(N_FU);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!found && buf_valid_q[scan_idx]) begin
               found           = 1'b1;
               gidx            = scan_idx;
               grant[scan_idx] = 1'b1;
            end
         end
      end
   end

   assign rr_ptr_d = (gidx == PTR_W'(N_FU-1)) ? '0 : gidx + 1'b1;
   assign g_tag    = buf_tag_q[gidx];
   assign g_value  = buf_value_q[gidx];

   // A granted buffer drains this cycle, so it can take a new result at once.
   assign fu_ready = {N_FU{reset & ~squash}} & (~buf_valid_q | grant);
   assign accept   = fu_valid & fu_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         buf_valid_q   <= '0;
         buf_tag_q     <= '0;
         buf_value_q   <= '0;
         rr_ptr_q      <= '0;
         cdb_valid_q   <= 1'b0;
         cdb_tag_q     <= '0;
         cdb_value_q   <= '0;
         bcast_count_q <= '0;
      end else if (squash) begin
         buf_valid_q <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
      end else begin
         for (int i = 0; i < N_FU; i++) begin
            if (accept[i]) begin
               buf_valid_q[i] <= 1'b1;
               buf_tag_q[i]   <= fu_rob_tag[i*TAG_W +: TAG_W];
               buf_value_q[i] <= fu_value[i*XLEN +: XLEN];
            end else if (grant[i]) begin
               buf_valid_q[i] <= 1'b0;
            end
         end
         if (found) begin
            rr_ptr_q <= rr_ptr_d;
         end
         // Tag 0 is reserved: such a grant is consumed but never broadcast.
         if (found && (g_tag != '0)) begin
            cdb_valid_q   <= 1'b1;
            cdb_tag_q     <= g_tag;
            cdb_value_q   <= g_value;
            bcast_count_q <= bcast_count_q + 32'd1;
         end else begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
         end
      end
   end

   assign cdb_valid   = cdb_valid_q;
   assign cdb_rob_tag = cdb_tag_q;
   assign cdb_value   = cdb_value_q;
   assign grant_dbg   = grant;
   assign bcast_count = bcast_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: inputs change 1ns after posedge, outputs are
// checked on the falling edge against hand-computed values.
module tb_cdb_arbiter;

   localparam int N_FU  = 4;
   localparam int TAG_W = 5;
   localparam int XLEN  = 32;

   logic                    clock;
   logic                    reset;
   logic [N_FU-1:0]         fu_valid;
   logic [N_FU*TAG_W-1:0]   fu_rob_tag;
   logic [N_FU*XLEN-1:0]    fu_value;
   logic [N_FU-1:0]         fu_ready;
   logic                    squash;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_rob_tag;
   logic [XLEN-1:0]         cdb_value;
   logic [N_FU-1:0]         grant_dbg;
   logic [31:0]             bcast_count;

   int n_cmp;
   int n_err;

   cdb_arbiter #(.N_FU(N_FU), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clock       (clock),
      .reset       (reset),
      .fu_valid    (fu_valid),
      .fu_rob_tag  (fu_rob_tag),
      .fu_value    (fu_value),
      .fu_ready    (fu_ready),
      .squash      (squash),
      .cdb_valid   (cdb_valid),
      .cdb_rob_tag (cdb_rob_tag),
      .cdb_value   (cdb_value),
      .grant_dbg   (grant_dbg),
      .bcast_count (bcast_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_fu(input int i, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
      fu_valid[i]                  = 1'b1;
      fu_rob_tag[i*TAG_W +: TAG_W] = tag;
      fu_value[i*XLEN +: XLEN]     = val;
   endtask

   task automatic clr_fu();
      fu_valid   = '0;
      fu_rob_tag = '0;
      fu_value   = '0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      clr_fu();
      squash = 1'b0;
      reset  = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clr_fu();
      squash = 1'b0;
      reset  = 1'b0;

      // Reset state while held
      @(negedge clock);
      check("rst_ready", fu_ready, 4'b0000);
      check("rst_cdb_valid", cdb_valid, 0);
      check("rst_grant", grant_dbg, 0);
      check("rst_count", bcast_count, 0);
      reset = 1'b1;
      step();

      // Single FU
      set_fu(1, 5'd3, 32'hDEAD);
      @(negedge clock);
      check("single_ready_c0", fu_ready, 4'b1111);
      check("single_grant_c0", grant_dbg, 4'b0000);
      step(); clr_fu();
      @(negedge clock);
      check("single_grant_c1", grant_dbg, 4'b0010);
      check("single_cdbv_c1", cdb_valid, 0);
      step();
      @(negedge clock);
      check("single_cdbv_c2", cdb_valid, 1);
      check("single_tag_c2", cdb_rob_tag, 3);
      check("single_val_c2", cdb_value, 32'hDEAD);
      check("single_count", bcast_count, 1);
      step();
      @(negedge clock);
      check("single_cdbv_c3", cdb_valid, 0);
      check("single_tag_c3", cdb_rob_tag, 0);

      // Contention: all four at once from rr_ptr=0
      do_reset();
      for (int i = 0; i < N_FU; i++) set_fu(i, TAG_W'(i + 1), XLEN'(100 + i));
      step(); clr_fu();
      @(negedge clock);
      check("cont_grant_c1", grant_dbg, 4'b0001);
      check("cont_ready_c1", fu_ready, 4'b0001);
      step();
      for (int c = 2; c <= 5; c++) begin
         @(negedge clock);
         check($sformatf("cont_cdbv_c%0d", c), cdb_valid, 1);
         check($sformatf("cont_tag_c%0d", c), cdb_rob_tag, c - 1);
         check($sformatf("cont_val_c%0d", c), cdb_value, 100 + c - 2);
         step();
      end
      check("cont_count", bcast_count, 4);
      // rr_ptr back at 0: FU0 must beat FU3
      set_fu(0, 5'd9, 32'h9);
      set_fu(3, 5'd10, 32'hA);
      step(); clr_fu();
      @(negedge clock);
      check("cont_ptr0_grant", grant_dbg, 4'b0001);
      step();
      @(negedge clock);
      check("cont_ptr0_grant2", grant_dbg, 4'b1000);
      check("cont_ptr0_tag", cdb_rob_tag, 9);
      step();
      @(negedge clock);
      check("cont_ptr0_tag2", cdb_rob_tag, 10);

      // Fairness: FU0 keeps producing while FU2 waits
      do_reset();
      set_fu(0, 5'd10, 32'h10);
      set_fu(2, 5'd20, 32'h20);
      step();
      fu_valid[2] = 1'b0;
      set_fu(0, 5'd11, 32'h11);
      @(negedge clock);
      check("fair_grant_c1", grant_dbg, 4'b0001);
      check("fair_ready0_c1", fu_ready[0], 1);
      step();
      set_fu(0, 5'd12, 32'h12);
      @(negedge clock);
      check("fair_grant_c2", grant_dbg, 4'b0100);
      check("fair_ready0_c2", fu_ready[0], 0);
      check("fair_tag_c2", cdb_rob_tag, 10);
      step();
      @(negedge clock);
      check("fair_grant_c3", grant_dbg, 4'b0001);
      check("fair_ready0_c3", fu_ready[0], 1);
      check("fair_tag_c3", cdb_rob_tag, 20);
      step(); clr_fu();
      @(negedge clock);
      check("fair_grant_c4", grant_dbg, 4'b0001);
      check("fair_tag_c4", cdb_rob_tag, 11);
      step();
      @(negedge clock);
      check("fair_tag_c5", cdb_rob_tag, 12);
      check("fair_count", bcast_count, 4);
      step();

      // Back-to-back on FU3
      do_reset();
      for (int c = 0; c < 3; c++) begin
         set_fu(3, TAG_W'(5 + c), XLEN'(32'h500 + c));
         @(negedge clock);
         check($sformatf("b2b_ready3_c%0d", c), fu_ready[3], 1);
         if (c == 2) check("b2b_tag_c2", cdb_rob_tag, 5);
         step();
      end
      clr_fu();
      @(negedge clock);
      check("b2b_tag_c3", cdb_rob_tag, 6);
      check("b2b_cdbv_c3", cdb_valid, 1);
      step();
      @(negedge clock);
      check("b2b_tag_c4", cdb_rob_tag, 7);
      check("b2b_val_c4", cdb_value, 32'h502);
      step();
      @(negedge clock);
      check("b2b_cdbv_c5", cdb_valid, 0);
      check("b2b_count", bcast_count, 3);
      step();

      // Squash with FU0/FU1 buffered (count stays at 3)
      set_fu(0, 5'd1, 32'h1);
      set_fu(1, 5'd2, 32'h2);
      step(); clr_fu();
      squash = 1'b1;
      set_fu(0, 5'd9, 32'h9);
      @(negedge clock);
      check("sq_ready_c1", fu_ready, 4'b0000);
      check("sq_grant_c1", grant_dbg, 4'b0000);
      step(); clr_fu();
      squash = 1'b0;
      @(negedge clock);
      check("sq_cdbv_c2", cdb_valid, 0);
      check("sq_grant_c2", grant_dbg, 4'b0000);
      check("sq_ready_c2", fu_ready, 4'b1111);
      check("sq_count", bcast_count, 3);
      step();
      @(negedge clock);
      check("sq_cdbv_c3", cdb_valid, 0);

      // Illegal tag 0 is drained but never broadcast
      step();
      set_fu(2, 5'd0, 32'h55);
      step(); clr_fu();
      @(negedge clock);
      check("tag0_grant", grant_dbg, 4'b0100);
      step();
      @(negedge clock);
      check("tag0_cdbv", cdb_valid, 0);
      check("tag0_val", cdb_value, 0);
      check("tag0_count", bcast_count, 3);
      check("tag0_grant_after", grant_dbg, 4'b0000);
      step();

      // Asynchronous reset mid-cycle
      for (int i = 0; i < N_FU; i++) set_fu(i, TAG_W'(i + 1), XLEN'(200 + i));
      step(); clr_fu();
      step();
      #2;
      check("ar_pre_cdbv", cdb_valid, 1);
      reset = 1'b0;
      #1;
      check("ar_cdbv", cdb_valid, 0);
      check("ar_tag", cdb_rob_tag, 0);
      check("ar_val", cdb_value, 0);
      check("ar_count", bcast_count, 0);
      check("ar_grant", grant_dbg, 0);
      check("ar_ready", fu_ready, 4'b0000);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("ar_ready_rel", fu_ready, 4'b1111);
      step();
      @(negedge clock);
      check("ar_cdbv_after", cdb_valid, 0);
      check("ar_grant_after", grant_dbg, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
